// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: instruction/data memory handshake between sequencer and shared memory port
interface multi_cycle_ctrl_if;
  logic [15:0] ir_in;
  logic mem_ack;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  modport master (output mem_req, mem_we, addr_sel, input ir_in, mem_ack);
  modport slave (input mem_req, mem_we, addr_sel, output ir_in, mem_ack);
endinterface

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath selects with a memory watchdog
module multi_cycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int FLAG_Z = 0,
  parameter int FLAG_C = 1
) (
  input  logic clk,
  input  logic rst,
  multi_cycle_ctrl_if.master bus,
  input  logic [3:0] flags,
  output logic ir_ld,
  output logic pc_ld,
  output logic [1:0] pc_sel,
  output logic [2:0] rs1_sel,
  output logic [2:0] rs2_sel,
  output logic [2:0] wr_sel,
  output logic reg_we,
  output logic [1:0] fun_sel,
  output logic op2_sel,
  output logic [1:0] wb_sel,
  output logic in_en,
  output logic out_en,
  output logic halted,
  output logic bus_err,
  output logic ill_op
);
  localparam logic [4:0] OP_NOP = 5'd0, OP_SUB = 5'd2, OP_AND = 5'd3, OP_OR = 5'd4, OP_ADDI = 5'd5;
  localparam logic [4:0] OP_LD = 5'd8, OP_ST = 5'd9, OP_IN = 5'd10, OP_OUT = 5'd11;
  localparam logic [4:0] OP_JMP = 5'd16, OP_BZ = 5'd17, OP_BNZ = 5'd18, OP_BC = 5'd19, OP_HALT = 5'd31;
  typedef enum logic [2:0] {RST_S, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_nxt;
  logic [15:2] ir_q;
  logic [15:0] wd;
  logic [4:0] op;
  logic [2:0] rd, rs1, rs2;
  logic req, ack, tmo, legal, is_alu, is_ld, is_st, is_bcc, z, c, take, act, ex;
  assign op = ir_q[15:11];
  assign rd = ir_q[10:8];
  assign rs1 = ir_q[7:5];
  assign rs2 = ir_q[4:2];
  assign req = state == FETCH || state == MEM;
  assign ack = req && bus.mem_ack;
  assign tmo = MEM_TIMEOUT != 0 && req && !bus.mem_ack && wd + 16'd1 == 16'(MEM_TIMEOUT);
  assign legal = op inside {[5'd0:5'd5], [5'd8:5'd11], [5'd16:5'd20], 5'd31};
  assign is_alu = op inside {[5'd1:5'd5]};
  assign is_ld = op == OP_LD;
  assign is_st = op == OP_ST;
  assign is_bcc = op inside {[5'd17:5'd20]};
  assign z = |(flags & 4'(1 << FLAG_Z));
  assign c = |(flags & 4'(1 << FLAG_C));
  assign take = op == OP_BZ ? z : op == OP_BNZ ? !z : op == OP_BC ? c : !c;
  assign act = state inside {DECODE, EXEC, MEM, WB};
  assign ex = state inside {EXEC, MEM, WB};
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RST_S;
      ir_q <= '0;
      wd <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && bus.mem_ack) ir_q <= bus.ir_in[15:2];
      wd <= req && !bus.mem_ack ? wd + 16'd1 : 16'd0;
      bus_err <= bus_err | tmo;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      RST_S:   state_nxt = FETCH;
      FETCH:   state_nxt = tmo ? HALT : ack ? DECODE : FETCH;
      DECODE:  state_nxt = op == OP_HALT ? HALT : (op == OP_NOP || !legal) ? FETCH : EXEC;
      EXEC:    state_nxt = (is_alu || op == OP_IN) ? WB : (is_ld || is_st) ? MEM : FETCH;
      MEM:     state_nxt = tmo ? HALT : !ack ? MEM : is_ld ? WB : FETCH;
      WB:      state_nxt = FETCH;
      default: state_nxt = HALT;
    endcase
  end
  always_comb begin
    bus.mem_req = req;
    bus.addr_sel = state == MEM;
    bus.mem_we = state == MEM && is_st;
    ir_ld = state == FETCH && bus.mem_ack;
    pc_ld = ir_ld || (state == EXEC && (op == OP_JMP || (is_bcc && take)));
    pc_sel = state != EXEC ? 2'b00 : op == OP_JMP ? 2'b10 : (is_bcc && take) ? 2'b01 : 2'b00;
    rs1_sel = act ? rs1 : 3'd0;
    rs2_sel = !act ? 3'd0 : (state == MEM && is_st) ? rd : rs2;
    wr_sel = act ? rd : 3'd0;
    reg_we = state == WB;
    fun_sel = !ex ? 2'b00 : op == OP_SUB ? 2'b01 : op == OP_AND ? 2'b10 : op == OP_OR ? 2'b11 : 2'b00;
    op2_sel = ex && (op == OP_ADDI || is_ld || is_st);
    wb_sel = state != WB ? 2'b00 : is_ld ? 2'b01 : op == OP_IN ? 2'b10 : 2'b00;
    in_en = state == EXEC && op == OP_IN;
    out_en = state == EXEC && op == OP_OUT;
    halted = state == HALT;
    ill_op = state == DECODE && !legal;
  end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed and random instruction streams checked against a per-cycle trace model
module tb_multi_cycle_ctrl;
  localparam int TO = 4;
  typedef struct packed {
    logic mem_req, mem_we, addr_sel, ir_ld, pc_ld;
    logic [1:0] pc_sel;
    logic [2:0] rs1_sel, rs2_sel, wr_sel;
    logic reg_we;
    logic [1:0] fun_sel;
    logic op2_sel;
    logic [1:0] wb_sel;
    logic in_en, out_en, halted, bus_err, ill_op;
  } outs_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] flags = 4'd0;
  logic ir_ld, pc_ld, reg_we, op2_sel, in_en, out_en, halted, bus_err, ill_op;
  logic [1:0] pc_sel, fun_sel, wb_sel;
  logic [2:0] rs1_sel, rs2_sel, wr_sel;
  int tests = 0;
  int fails = 0;
  outs_t obs, strobes, all_m;
  logic [4:0] ops [19] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd11,
                           5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd6, 5'd7, 5'd24, 5'd30};
  multi_cycle_ctrl_if bus ();
  multi_cycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flags(flags), .ir_ld(ir_ld), .pc_ld(pc_ld),
    .pc_sel(pc_sel), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .wr_sel(wr_sel), .reg_we(reg_we),
    .fun_sel(fun_sel), .op2_sel(op2_sel), .wb_sel(wb_sel), .in_en(in_en), .out_en(out_en),
    .halted(halted), .bus_err(bus_err), .ill_op(ill_op)
  );
  always #5 clk = ~clk;
  assign obs = {bus.mem_req, bus.mem_we, bus.addr_sel, ir_ld, pc_ld, pc_sel, rs1_sel, rs2_sel, wr_sel,
                reg_we, fun_sel, op2_sel, wb_sel, in_en, out_en, halted, bus_err, ill_op};
  task automatic cyc(input logic r, input string tag, input logic ack, input logic [15:0] ir,
                     input logic [3:0] fl, input outs_t e, input outs_t m);
    @(negedge clk);
    rst = r;
    bus.mem_ack = ack;
    bus.ir_in = ir;
    flags = fl;
    #1;
    tests++;
    assert ((obs & m) === (e & m)) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (mask %h)", tag, obs & m, e & m, m);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    cyc(0, "rst_hold1", 1'($urandom), 16'($urandom), 4'($urandom), '0, all_m);
    cyc(0, "rst_hold2", 1'($urandom), 16'($urandom), 4'($urandom), '0, all_m);
    cyc(1, "rst_release", 1'($urandom), 16'($urandom), 4'($urandom), '0, all_m);
  endtask
  task automatic halt_cycles(input logic err, input int n);
    outs_t e;
    for (int k = 0; k < n; k++) begin
      e = '0;
      e.halted = 1'b1;
      e.bus_err = err;
      cyc(1, err ? "halt_buserr" : "halt", 1'($urandom), 16'($urandom), 4'($urandom), e, strobes);
    end
  endtask
  task automatic run_instr(input logic [15:0] ir, input int fw, input int mw,
                           input logic force_fl, input logic [3:0] xfl);
    logic [4:0] op;
    logic [3:0] fl;
    logic legal, alu, ld, st, take;
    outs_t e, m, se, sm;
    op = ir[15:11];
    for (int k = 0; k <= fw && k < TO; k++) begin
      e = '0;
      m = strobes;
      m.addr_sel = 1'b1;
      e.mem_req = 1'b1;
      if (k == fw) begin
        e.ir_ld = 1'b1;
        e.pc_ld = 1'b1;
        m.pc_sel = '1;
      end
      cyc(1, "fetch", k == fw, k == fw ? ir : 16'($urandom), 4'($urandom), e, m);
    end
    if (fw >= TO) begin
      halt_cycles(1, 6);
      return;
    end
    legal = op inside {[5'd0:5'd5], [5'd8:5'd11], [5'd16:5'd20], 5'd31};
    alu = op >= 5'd1 && op <= 5'd5;
    ld = op == 5'd8;
    st = op == 5'd9;
    se = '0;
    sm = strobes;
    se.rs1_sel = ir[7:5];
    se.rs2_sel = ir[4:2];
    se.wr_sel = ir[10:8];
    sm.rs1_sel = '1;
    sm.rs2_sel = '1;
    sm.wr_sel = '1;
    e = se;
    e.ill_op = !legal;
    cyc(1, "decode", 1'($urandom), 16'($urandom), 4'($urandom), e, sm);
    if (op == 5'd0 || !legal) return;
    if (op == 5'd31) begin
      halt_cycles(0, 20);
      return;
    end
    fl = force_fl ? xfl : 4'($urandom);
    take = op == 5'd17 ? fl[0] : op == 5'd18 ? !fl[0] : op == 5'd19 ? fl[1] : op == 5'd20 ? !fl[1] : 1'b0;
    e = se;
    m = sm;
    if (alu || ld || st) begin
      m.fun_sel = '1;
      m.op2_sel = 1'b1;
      e.fun_sel = op == 5'd2 ? 2'd1 : op == 5'd3 ? 2'd2 : op == 5'd4 ? 2'd3 : 2'd0;
      e.op2_sel = op == 5'd5 || ld || st;
    end
    e.in_en = op == 5'd10;
    e.out_en = op == 5'd11;
    m.pc_sel = '1;
    if (op == 5'd16 || take) begin
      e.pc_ld = 1'b1;
      e.pc_sel = op == 5'd16 ? 2'd2 : 2'd1;
    end
    cyc(1, "exec", 1'($urandom), 16'($urandom), fl, e, m);
    if (ld || st) begin
      for (int k = 0; k <= mw && k < TO; k++) begin
        e = se;
        m = sm;
        m.addr_sel = 1'b1;
        e.mem_req = 1'b1;
        e.addr_sel = 1'b1;
        e.mem_we = st;
        if (st) e.rs2_sel = ir[10:8];
        cyc(1, "mem", k == mw, 16'($urandom), 4'($urandom), e, m);
      end
      if (mw >= TO) begin
        halt_cycles(1, 6);
        return;
      end
      if (st) return;
    end
    if (alu || ld || op == 5'd10) begin
      e = se;
      m = sm;
      m.wb_sel = '1;
      e.reg_we = 1'b1;
      e.wb_sel = ld ? 2'd1 : op == 5'd10 ? 2'd2 : 2'd0;
      cyc(1, "wb", 1'($urandom), 16'($urandom), 4'($urandom), e, m);
    end
  endtask
  initial begin
    strobes = '0;
    {strobes.mem_req, strobes.mem_we, strobes.ir_ld, strobes.pc_ld, strobes.reg_we} = '1;
    {strobes.in_en, strobes.out_en, strobes.halted, strobes.bus_err, strobes.ill_op} = '1;
    all_m = '1;
    bus.mem_ack = 1'b0;
    bus.ir_in = 16'd0;
    do_reset();
    run_instr(16'b00001_011_001_010_00, 0, 0, 0, 4'd0);
    run_instr(16'b01000_101_010_00011, 0, 3, 0, 4'd0);
    run_instr(16'b01001_110_011_11101, 2, 1, 0, 4'd0);
    run_instr(16'b10001_000_0000_0101, 0, 0, 1, 4'b0001);
    run_instr(16'b10001_000_0000_0101, 0, 0, 1, 4'b0000);
    run_instr(16'b10011_000_0000_0101, 1, 0, 1, 4'b1110);
    run_instr(16'b10100_000_0000_0101, 0, 0, 1, 4'b1101);
    run_instr(16'b11000_000_0000_0000, 0, 0, 0, 4'd0);
    for (int i = 0; i < 150; i++)
      run_instr({ops[$urandom_range(0, 18)], 11'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3), 0, 4'd0);
    run_instr(16'h0800, TO, 0, 0, 4'd0);
    do_reset();
    run_instr(16'b01000_001_010_00001, 0, TO, 0, 4'd0);
    do_reset();
    run_instr({5'b11111, 11'($urandom)}, 0, 0, 0, 4'd0);
    do_reset();
    run_instr(16'b00010_100_101_110_00, 3, 0, 0, 4'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
